// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared timing constants for the VGA sync generator: default 640x480@60
// porch/sync widths, the derived line/frame totals, the counter width and a
// helper that sums the four segments of one axis.
// No ports (package).
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  // Width of the x/y counters; 10 bits covers totals up to 1023.
  localparam int CNT_W = 10;

  typedef logic [CNT_W-1:0] cnt_t;

  // Horizontal defaults, in pixels.
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;

  // Vertical defaults, in lines.
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  // Total of the four segments of one axis (display + front + sync + back).
  function automatic int span(input int disp, input int front,
                              input int sync, input int back);
    return disp + front + sync + back;
  endfunction

  localparam int DEF_H_TOTAL = span(DEF_H_DISPLAY, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK); // 800
  localparam int DEF_V_TOTAL = span(DEF_V_DISPLAY, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK); // 525

endpackage

// File: rtl/vga_mod_counter.sv
// -----------------------------------------------------------------------------
// vga_mod_counter
// Modulo-MOD up counter with enable. Counts 0..MOD-1 and wraps to 0 on an
// enabled cycle at MOD-1.
// Ports:
//   clk    - clock
//   reset  - synchronous active-low reset, clears the count
//   en     - advance enable
//   count  - current count (registered)
//   wrap   - combinational: en is high and count is at MOD-1 this cycle
// -----------------------------------------------------------------------------
module vga_mod_counter #(
  parameter int MOD = 800,
  parameter int W   = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign wrap  = en && (count_q == LAST);
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
// VGA horizontal/vertical timing generator. Two modulo counters walk the
// raster; sync, blanking and frame_end are decoded combinationally from the
// counter registers so they line up with x/y in the same cycle.
//
// Optional feature: define VGA_PIX_DIV_EN to divide clk by 4 with a 2-bit
// divider (100 MHz -> 25 MHz pixel rate). Without it, clk is the pixel clock
// and pixel_tick is high in every non-reset cycle.
//
// Ports:
//   clk        - system clock
//   reset      - synchronous active-low reset (has priority over ticks)
//   hsync      - horizontal sync, active low
//   vsync      - vertical sync, active low
//   video_on   - high inside the visible area
//   pixel_tick - one-clk pixel-rate enable
//   x, y       - current horizontal / vertical count
//   frame_end  - one-clk pulse on the tick of the last pixel of a frame
// -----------------------------------------------------------------------------
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic             clk,
  input  logic             reset,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             pixel_tick,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             frame_end
);

  localparam int H_TOTAL = span(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = span(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

  // Decode boundaries in counter width so comparisons stay width-matched.
  localparam cnt_t H_VIS_END  = cnt_t'(H_DISPLAY);
  localparam cnt_t H_SYNC_BEG = cnt_t'(H_DISPLAY + H_FRONT);
  localparam cnt_t H_SYNC_END = cnt_t'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam cnt_t V_VIS_END  = cnt_t'(V_DISPLAY);
  localparam cnt_t V_SYNC_BEG = cnt_t'(V_DISPLAY + V_FRONT);
  localparam cnt_t V_SYNC_END = cnt_t'(V_DISPLAY + V_FRONT + V_SYNC);

  logic tick;
  logic h_wrap;
  logic v_en;
  logic v_wrap;
  cnt_t h_count;
  cnt_t v_count;

`ifdef VGA_PIX_DIV_EN
  logic [1:0] div_q;
  logic [1:0] div_d;

  assign div_d = div_q + 2'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q <= 2'd0;
    end else begin
      div_q <= div_d;
    end
  end

  // Gating with reset keeps the tick (and frame_end) low while in reset.
  assign tick = reset && (div_q == 2'd3);
`else
  assign tick = reset;
`endif

  assign v_en = tick && h_wrap;

  vga_mod_counter #(
    .MOD (H_TOTAL),
    .W   (CNT_W)
  ) u_h_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (tick),
    .count (h_count),
    .wrap  (h_wrap)
  );

  vga_mod_counter #(
    .MOD (V_TOTAL),
    .W   (CNT_W)
  ) u_v_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (v_en),
    .count (v_count),
    .wrap  (v_wrap)
  );

  assign x          = h_count;
  assign y          = v_count;
  assign pixel_tick = tick;

  assign hsync    = !((h_count >= H_SYNC_BEG) && (h_count < H_SYNC_END));
  assign vsync    = !((v_count >= V_SYNC_BEG) && (v_count < V_SYNC_END));
  assign video_on = (h_count < H_VIS_END) && (v_count < V_VIS_END);

  // The vertical wrap is only enabled on a tick at the last pixel of a line,
  // so it fires exactly on the last pixel of the frame.
  assign frame_end = v_wrap;

endmodule

// File: tb/tb_vga_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_gen
// Directed bench for vga_sync_gen. Instance A uses the default 640x480
// timing, instance B a tiny 8x4 raster (14x7 totals) so full frames and
// frame-boundary behaviour can be exercised in a few hundred cycles.
// -----------------------------------------------------------------------------
module tb_vga_sync_gen;

`ifdef VGA_PIX_DIV_EN
  localparam int DIV = 4;
`else
  localparam int DIV = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       hs_a, vs_a, vo_a, pt_a, fe_a;
  logic [9:0] x_a, y_a;
  logic       hs_b, vs_b, vo_b, pt_b, fe_b;
  logic [9:0] x_b, y_b;

  int n_vec = 0;
  int n_err = 0;

  // Expected x positions of hsync transitions within a line.
  logic [9:0] exp_q[$];

  vga_sync_gen u_dut_a (
    .clk        (clk),
    .reset      (rst_a),
    .hsync      (hs_a),
    .vsync      (vs_a),
    .video_on   (vo_a),
    .pixel_tick (pt_a),
    .x          (x_a),
    .y          (y_a),
    .frame_end  (fe_a)
  );

  vga_sync_gen #(
    .H_DISPLAY (8), .H_FRONT (2), .H_SYNC (2), .H_BACK (2),
    .V_DISPLAY (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1)
  ) u_dut_b (
    .clk        (clk),
    .reset      (rst_b),
    .hsync      (hs_b),
    .vsync      (vs_b),
    .video_on   (vo_b),
    .pixel_tick (pt_b),
    .x          (x_b),
    .y          (y_b),
    .frame_end  (fe_b)
  );

  // ---------------- driver tasks ----------------
  // All sampling and driving happens 1 time unit after a rising edge.
  task automatic tick_a();
    for (int i = 0; i < 8; i++) begin
      if (pt_a === 1'b1) begin
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    n_err++;
    $display("FAIL tick_a_timeout: no pixel_tick within 8 clk, expected one within %0d", DIV);
  endtask

  task automatic tick_b();
    for (int i = 0; i < 8; i++) begin
      if (pt_b === 1'b1) begin
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    n_err++;
    $display("FAIL tick_b_timeout: no pixel_tick within 8 clk, expected one within %0d", DIV);
  endtask

  task automatic reset_a();
    rst_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b1;
  endtask

  task automatic reset_b();
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Values while held in reset.
    n_vec++; if (x_a !== 10'd0) begin n_err++; $display("FAIL rst_x: got %0d expected 0", x_a); end
    n_vec++; if (y_a !== 10'd0) begin n_err++; $display("FAIL rst_y: got %0d expected 0", y_a); end
    n_vec++; if (hs_a !== 1'b1) begin n_err++; $display("FAIL rst_hsync: got %b expected 1", hs_a); end
    n_vec++; if (vs_a !== 1'b1) begin n_err++; $display("FAIL rst_vsync: got %b expected 1", vs_a); end
    n_vec++; if (vo_a !== 1'b1) begin n_err++; $display("FAIL rst_video_on: got %b expected 1", vo_a); end
    n_vec++; if (pt_a !== 1'b0) begin n_err++; $display("FAIL rst_pixel_tick: got %b expected 0", pt_a); end
    n_vec++; if (fe_a !== 1'b0) begin n_err++; $display("FAIL rst_frame_end: got %b expected 0", fe_a); end
    // First cycle after release.
    rst_a = 1'b1;
    rst_b = 1'b1;
    #1;
    n_vec++; if (x_a !== 10'd0 || y_a !== 10'd0) begin n_err++; $display("FAIL rel_xy: got %0d,%0d expected 0,0", x_a, y_a); end
    n_vec++; if (hs_a !== 1'b1 || vs_a !== 1'b1) begin n_err++; $display("FAIL rel_sync: got hs=%b vs=%b expected 1,1", hs_a, vs_a); end
    n_vec++; if (vo_a !== 1'b1) begin n_err++; $display("FAIL rel_video_on: got %b expected 1", vo_a); end
    n_vec++; if (fe_a !== 1'b0) begin n_err++; $display("FAIL rel_frame_end: got %b expected 0", fe_a); end
`ifdef VGA_PIX_DIV_EN
    // Divider: tick low for the first three clk after release, high on the 4th.
    for (int n = 0; n < 4; n++) begin
      n_vec++;
      if (pt_a !== (n == 3)) begin
        n_err++; $display("FAIL rel_tick_clk%0d: got %b expected %b", n + 1, pt_a, (n == 3));
      end
      @(posedge clk); #1;
    end
`endif
  endtask

  task automatic test_line();
    int   e_x = 0, e_hs = 0, e_vo = 0, e_vs = 0, e_fe = 0, hs_low = 0;
    logic hs_prev = 1'b1;
    logic exp_hs, exp_vo;
    reset_a();
    exp_q.delete();
    exp_q.push_back(10'd656);
    exp_q.push_back(10'd752);
    for (int i = 0; i < 800; i++) begin
      exp_hs = !((i >= 656) && (i < 752));
      exp_vo = (i < 640);
      if (x_a !== 10'(i)) e_x++;
      if (hs_a !== exp_hs) e_hs++;
      if (vo_a !== exp_vo) e_vo++;
      if (vs_a !== 1'b1 || y_a !== 10'd0) e_vs++;
      if (fe_a !== 1'b0) e_fe++;
      if (hs_a === 1'b0) hs_low++;
      if (hs_a !== hs_prev) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL line_hs_edge: unexpected edge at x=%0d", x_a);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          if (x_a !== e) begin n_err++; $display("FAIL line_hs_edge: got x=%0d expected x=%0d", x_a, e); end
        end
      end
      hs_prev = hs_a;
      tick_a();
    end
    n_vec++; if (e_x != 0) begin n_err++; $display("FAIL line_x_seq: got %0d bad ticks expected 0", e_x); end
    n_vec++; if (e_hs != 0) begin n_err++; $display("FAIL line_hsync: got %0d bad ticks expected 0", e_hs); end
    n_vec++; if (e_vo != 0) begin n_err++; $display("FAIL line_video_on: got %0d bad ticks expected 0", e_vo); end
    n_vec++; if (e_vs != 0) begin n_err++; $display("FAIL line_vsync_y: got %0d bad ticks expected 0", e_vs); end
    n_vec++; if (e_fe != 0) begin n_err++; $display("FAIL line_frame_end: got %0d pulses expected 0", e_fe); end
    n_vec++; if (hs_low != 96) begin n_err++; $display("FAIL line_hs_width: got %0d expected 96", hs_low); end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL line_hs_edges_left: got %0d expected 0", exp_q.size()); end
    n_vec++; if (x_a !== 10'd0 || y_a !== 10'd1) begin n_err++; $display("FAIL line_wrap: got %0d,%0d expected 0,1", x_a, y_a); end
  endtask

  task automatic test_midframe_reset();
    reset_a();
    for (int i = 0; i < 2 * 800 + 300; i++) tick_a();
    n_vec++; if (x_a !== 10'd300 || y_a !== 10'd2) begin n_err++; $display("FAIL mid_pos: got %0d,%0d expected 300,2", x_a, y_a); end
    rst_a = 1'b0;
    #1;
    n_vec++; if (pt_a !== 1'b0 || fe_a !== 1'b0) begin n_err++; $display("FAIL mid_rst_tick: got pt=%b fe=%b expected 0,0", pt_a, fe_a); end
    @(posedge clk); #1;
    n_vec++; if (x_a !== 10'd0 || y_a !== 10'd0) begin n_err++; $display("FAIL mid_rst_xy: got %0d,%0d expected 0,0", x_a, y_a); end
    rst_a = 1'b1;
  endtask

  task automatic test_small_frame();
    int t0, ex, ey, e_xy = 0, e_hs = 0, e_vs = 0, e_vo = 0, fe_cnt = 0, fe_x = -1, fe_y = -1, hs_low = 0;
    reset_b();
    t0 = cyc;
    for (int i = 0; i < 98; i++) begin
      ex = i % 14;
      ey = i / 14;
      if (x_b !== 10'(ex) || y_b !== 10'(ey)) e_xy++;
      if (hs_b !== !((ex >= 10) && (ex < 12))) e_hs++;
      if (vs_b !== !(ey == 5)) e_vs++;
      if (vo_b !== ((ex < 8) && (ey < 4))) e_vo++;
      if (hs_b === 1'b0) hs_low++;
      if (fe_b === 1'b1) begin fe_cnt++; fe_x = int'(x_b); fe_y = int'(y_b); end
      tick_b();
    end
    n_vec++; if (e_xy != 0) begin n_err++; $display("FAIL frame_xy_seq: got %0d bad ticks expected 0", e_xy); end
    n_vec++; if (e_hs != 0) begin n_err++; $display("FAIL frame_hsync: got %0d bad ticks expected 0", e_hs); end
    n_vec++; if (hs_low != 14) begin n_err++; $display("FAIL frame_hs_low: got %0d expected 14", hs_low); end
    n_vec++; if (e_vs != 0) begin n_err++; $display("FAIL frame_vsync: got %0d bad ticks expected 0", e_vs); end
    n_vec++; if (e_vo != 0) begin n_err++; $display("FAIL frame_video_on: got %0d bad ticks expected 0", e_vo); end
    n_vec++; if (fe_cnt != 1) begin n_err++; $display("FAIL frame_end_count: got %0d expected 1", fe_cnt); end
    n_vec++; if (fe_x != 13 || fe_y != 6) begin n_err++; $display("FAIL frame_end_pos: got %0d,%0d expected 13,6", fe_x, fe_y); end
    n_vec++; if (x_b !== 10'd0 || y_b !== 10'd0) begin n_err++; $display("FAIL frame_wrap: got %0d,%0d expected 0,0", x_b, y_b); end
    n_vec++; if (cyc - t0 != 98 * DIV) begin n_err++; $display("FAIL frame_len_clk: got %0d expected %0d", cyc - t0, 98 * DIV); end
  endtask

  task automatic test_reset_at_frame_end();
    reset_b();
    for (int i = 0; i < 97; i++) tick_b();
    n_vec++; if (x_b !== 10'd13 || y_b !== 10'd6) begin n_err++; $display("FAIL fe_rst_pos: got %0d,%0d expected 13,6", x_b, y_b); end
    rst_b = 1'b0;
    #1;
    n_vec++; if (fe_b !== 1'b0 || pt_b !== 1'b0) begin n_err++; $display("FAIL fe_rst_pulse: got fe=%b pt=%b expected 0,0", fe_b, pt_b); end
    @(posedge clk); #1;
    n_vec++; if (x_b !== 10'd0 || y_b !== 10'd0) begin n_err++; $display("FAIL fe_rst_xy: got %0d,%0d expected 0,0", x_b, y_b); end
    rst_b = 1'b1;
    tick_b();
    n_vec++; if (x_b !== 10'd1 || y_b !== 10'd0) begin n_err++; $display("FAIL fe_rst_resume: got %0d,%0d expected 1,0", x_b, y_b); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_line();
    test_midframe_reset();
    test_small_frame();
    test_reset_at_frame_end();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter H_DISPLAY, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16; H_SYNC, default 96; H_BACK, default 48: horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_DISPLAY, default 480, visible lines per frame.
REQ-004 SHALL have parameter V_FRONT, default 10; V_SYNC, default 2; V_BACK, default 33: vertical porch and sync widths in lines.
REQ-005 SHALL have port clk, input, 1, system clock (100 MHz nominal).
REQ-006 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-007 SHALL have port hsync, output, 1, horizontal sync, active low.
REQ-008 SHALL have port vsync, output, 1, vertical sync, active low.
REQ-009 SHALL have port video_on, output, 1, high while (x,y) is inside the visible area.
REQ-010 SHALL have port pixel_tick, output, 1, one-clk pixel-rate enable.
REQ-011 SHALL have port x, output, 10, current horizontal count.
REQ-012 SHALL have port y, output, 10, current vertical count.
REQ-013 SHALL have port frame_end, output, 1, one-clk pulse on the last pixel of a frame.

Function
REQ-014 SHALL hold h_count and v_count registers; x = h_count, y = v_count.
REQ-015 SHALL derive H_TOTAL = sum of the horizontal parameters (800) and V_TOTAL = sum of the vertical parameters (525).
REQ-016 SHALL advance the counters only in clk cycles where pixel_tick = 1.
REQ-017 SHALL wrap h_count from H_TOTAL-1 to 0 on a tick; otherwise it increments by 1.
REQ-018 SHALL increment v_count only on a tick where h_count = H_TOTAL-1, wrapping from V_TOTAL-1 to 0.
REQ-019 SHALL drive hsync low iff H_DISPLAY+H_FRONT <= h_count < H_DISPLAY+H_FRONT+H_SYNC (656..751 at defaults).
REQ-020 SHALL drive vsync low iff V_DISPLAY+V_FRONT <= v_count < V_DISPLAY+V_FRONT+V_SYNC (490..491 at defaults).
REQ-021 SHALL drive video_on = (h_count < H_DISPLAY) and (v_count < V_DISPLAY).
REQ-022 SHALL decode hsync, vsync and video_on combinationally from the counter registers only, so they are valid in the same cycle as x and y with zero latency.
REQ-023 SHALL assert frame_end iff pixel_tick = 1, h_count = H_TOTAL-1 and v_count = V_TOTAL-1.
REQ-024 SHALL never let either counter exceed its TOTAL-1 value.

Reset
REQ-025 SHALL, on a clk edge with reset = 0, clear h_count, v_count and the pixel divider to 0, including mid-line and mid-frame.
REQ-026 SHALL produce these values while in reset and in the first cycle after it: x = 0, y = 0, hsync = 1, vsync = 1, video_on = 1, pixel_tick = 0, frame_end = 0.
REQ-027 SHALL ignore any tick in a cycle with reset = 0; reset has priority.

Configuration
REQ-028 SHALL use macro VGA_PIX_DIV_EN: when defined, a 2-bit divider is cleared by reset and increments every clk, and pixel_tick = 1 when the divider = 3 (one pixel per 4 clk, 25 MHz from 100 MHz).
REQ-029 SHALL, without VGA_PIX_DIV_EN, contain no divider, drive pixel_tick = 1 in every non-reset cycle, and treat clk as the pixel clock.

Structure
REQ-030 SHALL take default timing constants, H_TOTAL/V_TOTAL and the counter width (10) from shared package vga_timing_pkg.
REQ-031 SHALL instantiate sub-module vga_mod_counter (parameter MOD, inputs clk/reset/en, outputs count and wrap) twice: horizontal with en = pixel_tick, and vertical with en = pixel_tick and horizontal wrap.

Verification
REQ-032 SHALL verify reset: release reset -> x = 0, y = 0, hsync = 1, vsync = 1, video_on = 1; with VGA_PIX_DIV_EN, the first pixel_tick occurs on the 4th clk after release.
REQ-033 SHALL verify line timing: run one line -> hsync low for exactly 96 ticks starting at x = 656, video_on low from x = 640 to 799, and x wraps 799 -> 0 while y goes 0 -> 1.
REQ-034 SHALL verify frame timing: run 800x525 ticks -> vsync low only for y = 490..491, frame_end pulses exactly once (at x = 799, y = 524), and the next tick gives x = 0, y = 0.
REQ-035 SHALL verify reset mid-frame: assert reset at x = 300, y = 200 for 1 clk -> x = 0 and y = 0 on the next edge, with no frame_end pulse.
REQ-036 SHALL verify a non-default configuration: H_DISPLAY = 8, H_FRONT = H_SYNC = H_BACK = 2, V_DISPLAY = 4, V_FRONT = V_SYNC = V_BACK = 1, built without VGA_PIX_DIV_EN -> one frame lasts exactly 14x7 = 98 clk and hsync is low only at x = 10..11.
